// File: rtl/morse_key_sequencer.sv
// Morse key front end: synchronises and debounces the raw key, times presses and releases
// in prescaled units, and emits dot/dash/end-of-character symbols plus word-gap pulses.
module morse_key_sequencer #(
    parameter int TICK_DIV  = 1000,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8,
    parameter int MAX_SYM   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             key_in,
    input  logic [CNT_W-1:0] dash_thresh,
    input  logic [CNT_W-1:0] char_gap,
    input  logic [CNT_W-1:0] word_gap,
    output logic [1:0]       morse_signal,
    output logic             word_end,
    output logic             char_overrun,
    output logic             busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int EW = $clog2(MAX_SYM + 2);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, WAIT_WORD} state_t;

    state_t           state, state_n;
    logic             sync1, key_s, key_db, key_db_d;
    logic [DW-1:0]    db_cnt;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] dur;
    logic [EW-1:0]    elem_cnt, elem_n;
    logic [1:0]       sym_n;
    logic             wend_n, ovr_n;
    logic             tick, db_rise, db_fall, db_edge;
    logic [CNT_W-1:0] gap_min;

    // Synchroniser and debouncer keep running while disabled so key_db always reflects the key
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            key_s    <= 1'b0;
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= key_in;
            key_s    <= sync1;
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign db_rise = key_db & ~key_db_d;
    assign db_fall = ~key_db & key_db_d;
    assign db_edge = db_rise | db_fall;
    assign tick    = (presc == PW'(TICK_DIV - 1));

    // Prescaler and duration restart on each debounced edge so durations are edge-aligned
    always_ff @(posedge clk) begin
        if (rst || !enable || db_edge) begin
            presc <= '0;
            dur   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && (dur != {CNT_W{1'b1}})) begin
                dur <= dur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            elem_cnt     <= '0;
            morse_signal <= 2'b00;
            word_end     <= 1'b0;
            char_overrun <= 1'b0;
        end else begin
            state        <= state_n;
            elem_cnt     <= elem_n;
            morse_signal <= sym_n;
            word_end     <= wend_n;
            char_overrun <= ovr_n;
        end
    end

    assign gap_min = (char_gap == '0) ? CNT_W'(1) : char_gap;

    // A key rise is tested before any gap threshold so it wins when both happen together
    always_comb begin
        state_n = state;
        elem_n  = elem_cnt;
        sym_n   = 2'b00;
        wend_n  = 1'b0;
        ovr_n   = char_overrun;
        if (!enable) begin
            state_n = IDLE;
            elem_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (db_rise) begin
                        state_n = PRESS;
                        elem_n  = '0;
                    end
                end
                PRESS: begin
                    if (db_fall) begin
                        sym_n = (dur >= dash_thresh) ? 2'b10 : 2'b01;
                        if (elem_cnt >= EW'(MAX_SYM)) begin
                            ovr_n = 1'b1;
                        end
                        if (elem_cnt <= EW'(MAX_SYM)) begin
                            elem_n = elem_cnt + 1'b1;
                        end
                        state_n = GAP;
                    end
                end
                GAP: begin
                    if (db_rise) begin
                        state_n = PRESS;
                    end else if (dur >= gap_min) begin
                        sym_n   = 2'b11;
                        ovr_n   = 1'b0;
                        elem_n  = '0;
                        state_n = WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (db_rise) begin
                        state_n = PRESS;
                        elem_n  = '0;
                    end else if (dur >= word_gap) begin
                        wend_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer: key waveforms from a segment table, observed output
// events (with cycle stamps) compared against hand-computed event tables.
module tb_morse_key_sequencer;

    logic       clk = 1'b0;
    logic       rst, enable, key_in;
    logic [7:0] dash_thresh, char_gap, word_gap;
    logic [1:0] morse_signal;
    logic       word_end, char_overrun, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    // Event kinds: 1 dot, 2 dash, 3 end-of-char, 4 word_end, 5 busy rise, 6 busy fall,
    // 7 overrun set, 8 overrun clear
    typedef struct {int scen; logic key; int hold;} seg_t;
    typedef struct {int scen; int cyc; int kind;} ev_t;

    seg_t segs[$];
    ev_t  exp_evs[$];
    ev_t  got[$];
    int   scen_wg[9];
    logic busy_p = 1'b0;
    logic ovr_p  = 1'b0;

    morse_key_sequencer #(
        .TICK_DIV(4), .DB_CYCLES(2), .CNT_W(8), .MAX_SYM(6)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .key_in(key_in),
        .dash_thresh(dash_thresh), .char_gap(char_gap), .word_gap(word_gap),
        .morse_signal(morse_signal), .word_end(word_end),
        .char_overrun(char_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (morse_signal != 2'b00) got.push_back('{0, cyc, int'(morse_signal)});
            if (word_end) got.push_back('{0, cyc, 4});
            if (busy && !busy_p) got.push_back('{0, cyc, 5});
            if (!busy && busy_p) got.push_back('{0, cyc, 6});
            if (char_overrun && !ovr_p) got.push_back('{0, cyc, 7});
            if (!char_overrun && ovr_p) got.push_back('{0, cyc, 8});
        end
        busy_p = busy;
        ovr_p  = char_overrun;
    end

    function automatic void add_seg(input int s, input logic k, input int h);
        segs.push_back('{s, k, h});
    endfunction

    function automatic void add_ev(input int s, input int c, input int k);
        exp_evs.push_back('{s, c, k});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic startWindow();
        @(posedge clk);
        #1;
        got.delete();
        @(negedge clk);
        base = cyc;
    endtask

    task automatic applyStimulus(input int s);
        startWindow();
        word_gap = scen_wg[s][7:0];
        foreach (segs[i]) begin
            if (segs[i].scen == s) begin
                key_in = segs[i].key;
                repeat (segs[i].hold) @(negedge clk);
            end
        end
    endtask

    task automatic compareEvents(input int s);
        ev_t e[$];
        int  n;
        foreach (exp_evs[i]) if (exp_evs[i].scen == s) e.push_back(exp_evs[i]);
        checkOutput($sformatf("scen%0d event_count", s), got.size(), e.size());
        n = (got.size() < e.size()) ? got.size() : e.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("scen%0d ev%0d cycle", s, i), got[i].cyc - base, e[i].cyc);
            checkOutput($sformatf("scen%0d ev%0d kind", s, i), got[i].kind, e[i].kind);
        end
    endtask

    initial begin
        for (int s = 0; s < 9; s++) scen_wg[s] = 7;
        // 0: 4-unit dash then long release
        add_seg(0, 1, 16); add_seg(0, 0, 60);
        add_ev(0, 5, 5); add_ev(0, 21, 2); add_ev(0, 34, 3); add_ev(0, 50, 4); add_ev(0, 50, 6);
        // 1: dot, 1-unit gap, dot, word gap
        add_seg(1, 1, 4); add_seg(1, 0, 4); add_seg(1, 1, 4); add_seg(1, 0, 60);
        add_ev(1, 5, 5); add_ev(1, 9, 1); add_ev(1, 17, 1); add_ev(1, 30, 3);
        add_ev(1, 46, 4); add_ev(1, 46, 6);
        // 2: one-cycle glitch is filtered
        add_seg(2, 1, 1); add_seg(2, 0, 20);
        // 3: seven dots, overrun on the 7th, cleared with end-of-char
        for (int i = 0; i < 6; i++) begin
            add_seg(3, 1, 4); add_seg(3, 0, 4);
        end
        add_seg(3, 1, 4); add_seg(3, 0, 60);
        add_ev(3, 5, 5);
        for (int i = 0; i < 7; i++) add_ev(3, 9 + 8 * i, 1);
        add_ev(3, 57, 7); add_ev(3, 70, 3); add_ev(3, 70, 8); add_ev(3, 86, 4); add_ev(3, 86, 6);
        // 4: rise lands exactly when char gap is reached
        add_seg(4, 1, 4); add_seg(4, 0, 13); add_seg(4, 1, 16); add_seg(4, 0, 60);
        add_ev(4, 5, 5); add_ev(4, 9, 1); add_ev(4, 38, 2); add_ev(4, 51, 3);
        add_ev(4, 67, 4); add_ev(4, 67, 6);
        // 5/6: press just below / at the dash threshold
        add_seg(5, 1, 12); add_seg(5, 0, 60);
        add_ev(5, 5, 5); add_ev(5, 17, 1); add_ev(5, 30, 3); add_ev(5, 46, 4); add_ev(5, 46, 6);
        add_seg(6, 1, 13); add_seg(6, 0, 60);
        add_ev(6, 5, 5); add_ev(6, 18, 2); add_ev(6, 31, 3); add_ev(6, 47, 4); add_ev(6, 47, 6);
        // 7: word_gap below char_gap, word_end one cycle after end-of-char
        scen_wg[7] = 2;
        add_seg(7, 1, 4); add_seg(7, 0, 40);
        add_ev(7, 5, 5); add_ev(7, 9, 1); add_ev(7, 22, 3); add_ev(7, 23, 4); add_ev(7, 23, 6);
        // 8: enable dropped in the gap
        add_ev(8, 5, 5); add_ev(8, 9, 1); add_ev(8, 13, 6);

        rst = 1'b1; enable = 1'b1; key_in = 1'b0;
        dash_thresh = 8'd3; char_gap = 8'd3; word_gap = 8'd7;
        repeat (3) @(negedge clk);
        checkOutput("reset morse_signal", morse_signal, 0);
        checkOutput("reset word_end", word_end, 0);
        checkOutput("reset char_overrun", char_overrun, 0);
        checkOutput("reset busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int s = 0; s < 8; s++) begin
            applyStimulus(s);
            compareEvents(s);
        end
        word_gap = 8'd7;

        // Reset during an 8th press after overrun was flagged
        startWindow();
        for (int i = 0; i < 7; i++) begin
            key_in = 1'b1; repeat (4) @(negedge clk);
            key_in = 1'b0; repeat (4) @(negedge clk);
        end
        key_in = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("pre-reset char_overrun", char_overrun, 1);
        checkOutput("pre-reset busy", busy, 1);
        rst = 1'b1;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midpress reset morse_signal", morse_signal, 0);
        checkOutput("midpress reset word_end", word_end, 0);
        checkOutput("midpress reset char_overrun", char_overrun, 0);
        checkOutput("midpress reset busy", busy, 0);
        rst = 1'b0;
        startWindow();
        repeat (60) @(negedge clk);
        checkOutput("post-reset event_count", got.size(), 0);

        // Enable dropped while waiting in the gap
        startWindow();
        key_in = 1'b1; repeat (4) @(negedge clk);
        key_in = 1'b0; repeat (8) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disable busy", busy, 0);
        repeat (30) @(negedge clk);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        compareEvents(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
